// File: rtl/pixel_pkg.sv
// Shared types and constants for the NeoPixel frame buffer.
//   pixel_t     : one GRB 8:8:8 pixel
//   state_e     : frame buffer engine states
//   PALETTE     : read-only colours mapped at the lowest addresses
//   palette_at(): palette lookup that returns 0 beyond the defined entries
package pixel_pkg;

    localparam int unsigned PIXEL_W   = 24;
    localparam int unsigned PALETTE_N = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    localparam pixel_t PALETTE [PALETTE_N] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF00FF,
        24'h00FFFF, 24'hFFFF00, 24'hFFFFFF, 24'h000000
    };

    // Loop compare keeps the lookup free of index-width truncation when the
    // caller's address is wider than the palette index.
    function automatic pixel_t palette_at(input int unsigned idx);
        pixel_t px;
        px = '0;
        for (int unsigned i = 0; i < PALETTE_N; i++) begin
            if (idx == i) begin
                px = PALETTE[i];
            end
        end
        return px;
    endfunction

endpackage

// File: rtl/pixel_ram_2r1w.sv
// DEPTH x DATA_W storage with one synchronous write port and two
// asynchronous read ports (CPU and scan). Contents are not reset.
//   i_clk              : clock
//   i_we/i_waddr/i_wdata : write port, commits at the rising edge
//   i_raddr_a/o_rdata_a  : CPU read port (combinational)
//   i_raddr_b/o_rdata_b  : scan read port (combinational)
module pixel_ram_2r1w #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write returns old data.
    assign o_rdata_a = mem[i_raddr_a];
    assign o_rdata_b = mem[i_raddr_b];

endmodule

// File: rtl/pixel_frame_buffer.sv
// Pixel store for the NeoPixel chain: writable RAM above a read-only palette.
//   i_clk, i_rst_n                 : clock, async active-low reset
//   i_rd_addr/i_rd_wen/i_rd_data   : CPU write port (palette addresses dropped)
//   i_rs_addr/o_rs_data            : CPU read port, one cycle latency
//   i_start/i_base/i_len           : scan launch (len 0..DEPTH)
//   o_px_valid/i_px_ready/o_px_data: scan stream to the serializer
//   o_frame_done                   : one-cycle pulse at end of scan or clear
//   i_clear                        : zero the writable region
//   o_busy                         : engine in SCAN or CLEAR
module pixel_frame_buffer
    import pixel_pkg::*;
#(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned N_CONST = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_rd_wen,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic [ADDR_W-1:0] i_rs_addr,
    output logic [DATA_W-1:0] o_rs_data,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_px_valid,
    input  logic              i_px_ready,
    output logic [DATA_W-1:0] o_px_data,
    output logic              o_frame_done,
    input  logic              i_clear,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] NCONST_A = ADDR_W'(N_CONST);
    localparam logic [ADDR_W-1:0] LAST_A   = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;     // next scan address to fetch
    logic [ADDR_W:0]   rem_q, rem_d;     // pixels still to be loaded
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic              px_valid_q, px_valid_d;
    logic [DATA_W-1:0] px_data_q, px_data_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] ram_rdata_cpu, ram_rdata_scan;
    logic [DATA_W-1:0] cpu_px, scan_px;

    function automatic logic [DATA_W-1:0] decode_rd(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] ram_px);
        if (addr < NCONST_A) begin
            return DATA_W'(palette_at(32'(addr)));
        end
        return ram_px;
    endfunction

    // The clear engine owns the single write port; CPU writes are dropped then.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = i_rd_addr;
        ram_wdata = i_rd_data;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_q;
            ram_wdata = '0;
        end else if (i_rd_wen && (i_rd_addr >= NCONST_A)) begin
            ram_we = 1'b1;
        end
    end

    // In IDLE the scan port looks at i_base so the first pixel is ready at start.
    assign scan_addr = (state_q == SCAN) ? ptr_q : i_base;

    pixel_ram_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_we      (ram_we),
        .i_waddr   (ram_waddr),
        .i_wdata   (ram_wdata),
        .i_raddr_a (i_rs_addr),
        .o_rdata_a (ram_rdata_cpu),
        .i_raddr_b (scan_addr),
        .o_rdata_b (ram_rdata_scan)
    );

    assign cpu_px  = decode_rd(i_rs_addr, ram_rdata_cpu);
    assign scan_px = decode_rd(scan_addr, ram_rdata_scan);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        clr_d      = clr_q;
        px_valid_d = px_valid_q;
        px_data_d  = px_data_q;
        done_d     = 1'b0;
        rs_data_d  = cpu_px;

        unique case (state_q)
            IDLE: begin
                if (i_clear) begin
                    state_d = CLEAR;
                    clr_d   = NCONST_A;
                end else if (i_start) begin
                    if (i_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = SCAN;
                        px_valid_d = 1'b1;
                        px_data_d  = scan_px;
                        ptr_d      = i_base + 1'b1;
                        rem_d      = i_len - 1'b1;
                    end
                end
            end
            SCAN: begin
                if (px_valid_q && i_px_ready) begin
                    if (rem_q != '0) begin
                        px_data_d = scan_px;
                        ptr_d     = ptr_q + 1'b1;
                        rem_d     = rem_q - 1'b1;
                    end else begin
                        px_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (clr_q == LAST_A) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                px_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            clr_q      <= '0;
            px_valid_q <= 1'b0;
            px_data_q  <= '0;
            done_q     <= 1'b0;
            rs_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            clr_q      <= clr_d;
            px_valid_q <= px_valid_d;
            px_data_q  <= px_data_d;
            done_q     <= done_d;
            rs_data_q  <= rs_data_d;
        end
    end

    assign o_rs_data    = rs_data_q;
    assign o_px_valid   = px_valid_q;
    assign o_px_data    = px_data_q;
    assign o_frame_done = done_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer (DATA_W=24, ADDR_W=8, N_CONST=8).
module tb_pixel_frame_buffer;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_wen;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [DATA_W-1:0] rs_data;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              px_valid;
    logic              px_ready;
    logic [DATA_W-1:0] px_data;
    logic              frame_done;
    logic              clear;
    logic              busy;

    int n_cmp;
    int n_err;

    pixel_frame_buffer #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .N_CONST (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rd_addr    (rd_addr),
        .i_rd_wen     (rd_wen),
        .i_rd_data    (rd_data),
        .i_rs_addr    (rs_addr),
        .o_rs_data    (rs_data),
        .i_start      (start),
        .i_base       (base),
        .i_len        (len),
        .o_px_valid   (px_valid),
        .i_px_ready   (px_ready),
        .o_px_data    (px_data),
        .o_frame_done (frame_done),
        .i_clear      (clear),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_px(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rd_wen  = 1'b1;
        rd_addr = a;
        rd_data = d;
        tick();
        rd_wen  = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] exp);
        rs_addr = a;
        tick();
        check_px(tag, rs_data, exp);
    endtask

    initial begin
        int busy_cycles;
        int done_seen;
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        rd_wen   = 1'b0;
        rd_data  = '0;
        rs_addr  = '0;
        start    = 1'b0;
        base     = '0;
        len      = '0;
        px_ready = 1'b0;
        clear    = 1'b0;

        tick();
        tick();
        check_px ("rst_rs_data", rs_data, 24'h000000);
        check_bit("rst_valid", px_valid, 1'b0);
        check_px ("rst_px_data", px_data, 24'h000000);
        check_bit("rst_done", frame_done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Palette read, then a dropped write to a palette address.
        cpu_read_check("pal3", 8'd3, 24'hFF00FF);
        cpu_write(8'd3, 24'h123456);
        cpu_read_check("pal3_after_wr", 8'd3, 24'hFF00FF);

        // RAM write and read-during-write.
        cpu_write(8'd20, 24'h0A0B0C);
        cpu_read_check("ram20", 8'd20, 24'h0A0B0C);
        rd_wen  = 1'b1;
        rd_addr = 8'd20;
        rd_data = 24'h111111;
        rs_addr = 8'd20;
        tick();
        rd_wen = 1'b0;
        check_px("rdw_old", rs_data, 24'h0A0B0C);
        tick();
        check_px("rdw_new", rs_data, 24'h111111);

        // Scan with address wrap into the palette.
        cpu_write(8'd254, 24'hAAAAAA);
        cpu_write(8'd255, 24'hBBBBBB);
        px_ready = 1'b1;
        start    = 1'b1;
        base     = 8'd254;
        len      = 9'd4;
        tick();
        start = 1'b0;
        check_bit("wrap_v0", px_valid, 1'b1);
        check_px ("wrap_p0", px_data, 24'hAAAAAA);
        check_bit("wrap_busy", busy, 1'b1);
        tick();
        check_px ("wrap_p1", px_data, 24'hBBBBBB);
        tick();
        check_px ("wrap_p2", px_data, 24'hFF0000);
        tick();
        check_px ("wrap_p3", px_data, 24'h00FF00);
        check_bit("wrap_v3", px_valid, 1'b1);
        check_bit("wrap_nodone", frame_done, 1'b0);
        tick();
        check_bit("wrap_end_valid", px_valid, 1'b0);
        check_bit("wrap_done", frame_done, 1'b1);
        check_bit("wrap_end_busy", busy, 1'b0);
        tick();
        check_bit("wrap_done_1cyc", frame_done, 1'b0);

        // Backpressure: ready pattern 1,0,0,1,1 over pixels at 20..22.
        cpu_write(8'd21, 24'h222222);
        cpu_write(8'd22, 24'h333333);
        start = 1'b1;
        base  = 8'd20;
        len   = 9'd3;
        tick();
        start = 1'b0;
        check_px ("bp_a", px_data, 24'h111111);
        px_ready = 1'b1;
        tick();
        check_px ("bp_b", px_data, 24'h222222);
        px_ready = 1'b0;
        start    = 1'b1;
        base     = 8'd254;
        len      = 9'd2;
        tick();
        start = 1'b0;
        check_px ("bp_c_hold", px_data, 24'h222222);
        check_bit("bp_c_valid", px_valid, 1'b1);
        tick();
        check_px ("bp_d_hold", px_data, 24'h222222);
        px_ready = 1'b1;
        tick();
        check_px ("bp_e", px_data, 24'h333333);
        check_bit("bp_e_valid", px_valid, 1'b1);
        tick();
        check_bit("bp_end_valid", px_valid, 1'b0);
        check_bit("bp_done", frame_done, 1'b1);
        tick();
        check_bit("bp_idle_busy", busy, 1'b0);
        check_bit("bp_no_restart", px_valid, 1'b0);

        // Clear: fill, clear, count busy cycles, try a write mid-clear.
        for (int a = 8; a < 256; a++) begin
            cpu_write(ADDR_W'(a), 24'hFFFFFF);
        end
        clear = 1'b1;
        tick();
        clear       = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            busy_cycles++;
            rd_wen  = (i == 100);
            rd_addr = 8'd50;
            rd_data = 24'h555555;
            tick();
        end
        rd_wen = 1'b0;
        check_int("clr_busy_cycles", busy_cycles, 248);
        check_bit("clr_done", frame_done, 1'b1);
        tick();
        check_bit("clr_done_1cyc", frame_done, 1'b0);
        cpu_read_check("clr_a8", 8'd8, 24'h000000);
        cpu_read_check("clr_a255", 8'd255, 24'h000000);
        cpu_read_check("clr_wr_dropped", 8'd50, 24'h000000);
        cpu_read_check("clr_pal0", 8'd0, 24'hFF0000);
        cpu_read_check("clr_pal5", 8'd5, 24'hFFFF00);

        // Reset mid-scan.
        px_ready = 1'b0;
        start    = 1'b1;
        base     = 8'd0;
        len      = 9'd10;
        tick();
        start = 1'b0;
        check_bit("mid_valid", px_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_valid", px_valid, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b0);
        check_px ("mid_rst_data", px_data, 24'h000000);
        tick();
        rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (frame_done) done_seen++;
        end
        check_int("mid_rst_no_done", done_seen, 0);

        // Zero-length start.
        start = 1'b1;
        len   = 9'd0;
        tick();
        start = 1'b0;
        check_bit("zero_done", frame_done, 1'b1);
        check_bit("zero_busy", busy, 1'b0);
        tick();
        check_bit("zero_done_1cyc", frame_done, 1'b0);
        check_bit("zero_busy2", busy, 1'b0);

        // Clear beats start when both arrive together.
        clear = 1'b1;
        start = 1'b1;
        len   = 9'd2;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check_bit("prio_busy", busy, 1'b1);
        check_bit("prio_no_valid", px_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_frame_buffer.md
Name: pixel_frame_buffer

Overview:
- Parametrised pixel store for the NeoPixel chain: a writable RAM region above a read-only constant colour palette at the low addresses.
- CPU side: one write port and one registered read port.
- Scan side: a streaming engine that reads a programmable run of pixels (base, length, address wrap) and presents them to the serializer over a valid/ready handshake.
- A hardware clear engine zeroes the writable region.

Parameters:
- DATA_W, 24, pixel width in bits (GRB 8:8:8).
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W entries.
- N_CONST, 8, number of read-only palette entries at addresses 0..N_CONST-1. Must satisfy 0 <= N_CONST < DEPTH.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rd_addr  in  ADDR_W  CPU write address.
- i_rd_wen  in  1  CPU write enable.
- i_rd_data  in  DATA_W  CPU write data.
- i_rs_addr  in  ADDR_W  CPU read address.
- o_rs_data  out  DATA_W  CPU read data, registered.
- i_start  in  1  scan start pulse.
- i_base  in  ADDR_W  first scan address, sampled on an accepted i_start.
- i_len  in  ADDR_W+1  pixel count, 0..DEPTH, sampled on an accepted i_start.
- o_px_valid  out  1  scan pixel valid.
- i_px_ready  in  1  serializer ready.
- o_px_data  out  DATA_W  scan pixel.
- o_frame_done  out  1  one-cycle pulse at the end of a scan or clear.
- i_clear  in  1  clear request pulse.
- o_busy  out  1  high in SCAN or CLEAR.

Behaviour:
- Reset (async assert, sync release):
  - o_rs_data = 0, o_px_valid = 0, o_px_data = 0, o_frame_done = 0, o_busy = 0; state = IDLE; counters = 0.
  - RAM contents are not reset.
  - Assertion mid-scan or mid-clear aborts the operation; no o_frame_done is issued.
- Address decode (CPU and scan reads): addr < N_CONST returns the constant PALETTE[addr]; otherwise returns mem[addr].
- CPU write:
  - Commits at the clock edge when i_rd_wen=1 and i_rd_addr >= N_CONST.
  - Writes to palette addresses are silently dropped.
  - Writes are dropped while state = CLEAR; they are accepted in IDLE and SCAN.
- CPU read:
  - Latency 1: o_rs_data at edge N+1 reflects i_rs_addr sampled at edge N.
  - Read and write to the same address in the same cycle returns the old data.
- State machine: IDLE, SCAN, CLEAR.
  - IDLE -> CLEAR on i_clear. i_clear has priority if i_clear and i_start are asserted together.
  - IDLE -> SCAN on i_start with i_len != 0.
  - i_start with i_len == 0 in IDLE: stay in IDLE, pulse o_frame_done the next cycle.
  - i_start and i_clear are ignored outside IDLE.
- SCAN:
  - Pointer starts at i_base and increments modulo DEPTH (255 -> 0 for ADDR_W=8).
  - o_px_valid first asserts exactly 1 cycle after the accepted i_start.
  - While o_px_valid=1 and i_px_ready=0, o_px_data and o_px_valid hold stable.
  - A handshake is o_px_valid & i_px_ready. With i_px_ready held high, sustain 1 pixel per cycle with no bubbles.
  - Each pixel is fetched from memory on the cycle it is loaded into the output register. A CPU write lands in the stream only if committed before that fetch.
  - After the i_len-th handshake: o_px_valid=0 and o_frame_done=1 on the next cycle, then IDLE.
- CLEAR:
  - Writes 0 to addresses N_CONST..DEPTH-1, one per cycle, ascending; takes DEPTH-N_CONST cycles.
  - o_frame_done pulses the cycle after the last write, then IDLE.
- o_busy = (state != IDLE).
- o_frame_done is never high for more than one consecutive cycle.

Decomposition:
- Package pixel_pkg holds:
  - the pixel typedef (DATA_W);
  - the state enum {IDLE, SCAN, CLEAR};
  - the default PALETTE constant array: FF0000, 00FF00, 0000FF, FF00FF, 00FFFF, FFFF00, FFFFFF, 000000, for entries 0..7.
- One sub-module, pixel_ram_2r1w: DEPTH x DATA_W, one write port, two asynchronous-read ports (CPU and scan). The palette decode and the registering of read data live in the top level.

Test Plan:
- Palette read: reset, then i_rs_addr=3 -> o_rs_data=FF00FF one cycle later. Write 123456 to address 3, read back -> still FF00FF.
- RAM write/readback: write 0A0B0C to address 20 -> read address 20 returns 0A0B0C. Same-cycle write 111111 to 20 while reading 20 -> o_rs_data=0A0B0C, then 111111 on the following read.
- Scan with wrap: mem[254]=AAAAAA, mem[255]=BBBBBB; i_start, i_base=254, i_len=4, i_px_ready=1 -> pixels AAAAAA, BBBBBB, FF0000, 00FF00 on 4 consecutive cycles; o_frame_done on the 5th cycle after the first valid.
- Backpressure: i_len=3 with i_px_ready toggling 1,0,0,1,1 -> data held stable during stalls, exactly 3 handshakes, no duplicated or skipped pixels; a mid-scan i_start is ignored.
- Clear: fill RAM with FFFFFF, pulse i_clear -> o_busy high for 248 cycles, then done pulse. Reads of addresses 8 and 255 return 0; palette entries unchanged; CPU writes during clear are dropped.
- Reset mid-scan and zero length: deassert i_rst_n during a scan -> o_px_valid and o_busy drop immediately, no o_frame_done. Then i_start with i_len=0 -> o_frame_done pulses once, o_busy stays 0.
